mod_updown_counter: RTL and testbench

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter_if.sv | 26 ++
 rtl/mod_updown_counter.sv | 75 +++++++
 tb/tb_mod_updown_counter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mod_updown_counter_if.sv
// Bus bundle for mod_updown_counter: load/limit/count controls in, counter state and flags out.
interface mod_updown_counter_if #(
    parameter int DATA_BITS = 16
);
    logic [DATA_BITS-1:0] data;
    logic                 load;
    logic [DATA_BITS-1:0] limit_data;
    logic                 limit_load;
    logic                 count;
    logic                 down;
    logic [DATA_BITS-1:0] out;
    logic [DATA_BITS-1:0] limit;
    logic                 carry;
    logic                 borrow;
    logic                 wrap;

    modport master (
        output data, load, limit_data, limit_load, count, down,
        input  out, limit, carry, borrow, wrap
    );

    modport slave (
        input  data, load, limit_data, limit_load, count, down,
        output out, limit, carry, borrow, wrap
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with a runtime limit register and a one-cycle wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the end points instead of wrapping.
module mod_updown_counter #(
    parameter int DATA_BITS = 16,
    parameter int MAX_VALUE = 1
) (
    input  logic              clk,
    input  logic              clear,
    mod_updown_counter_if.slave bus
);
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [DATA_BITS-1:0] RST_LIMIT = DATA_BITS'(MAX_VALUE);

    // Initialisers give the reset state from time zero without a clear pulse.
    logic [DATA_BITS-1:0] out_q   = '0;
    logic [DATA_BITS-1:0] limit_q = RST_LIMIT;
    logic                 wrap_q  = 1'b0;

    logic [DATA_BITS-1:0] out_d, limit_d, eff_limit;
    logic                 wrap_d;

    assign eff_limit = bus.limit_load ? bus.limit_data : limit_q;

    always_comb begin
        out_d   = out_q;
        limit_d = limit_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            limit_d = eff_limit;
            out_d   = (bus.data > eff_limit) ? eff_limit : bus.data;
        end else if (bus.limit_load) begin
            // Shrinking below the current count restarts from zero.
            limit_d = bus.limit_data;
            out_d   = (out_q > bus.limit_data) ? '0 : out_q;
        end else if (bus.count) begin
            if (!bus.down) begin
                if (out_q == limit_q) begin
                    out_d  = SAT ? out_q : '0;
                    wrap_d = !SAT;
                end else begin
                    out_d = out_q + 1'b1;
                end
            end else begin
                if (out_q == '0) begin
                    out_d  = SAT ? out_q : limit_q;
                    wrap_d = !SAT;
                end else begin
                    out_d = out_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            out_q   <= '0;
            limit_q <= RST_LIMIT;
            wrap_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.limit  = limit_q;
    assign bus.wrap   = wrap_q;
    assign bus.carry  = !bus.down && (out_q == limit_q);
    assign bus.borrow = bus.down && (out_q == '0);
endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector bench for mod_updown_counter (DATA_BITS=8, MAX_VALUE=5), both build variants.
module tb_mod_updown_counter;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int EO_WR[7] = '{1, 2, 3, 4, 5, 0, 1};
    localparam int EO_SA[7] = '{1, 2, 3, 4, 5, 5, 5};
    localparam int EW_WR[7] = '{0, 0, 0, 0, 0, 1, 0};
    localparam int EC_WR[7] = '{0, 0, 0, 0, 1, 0, 0};
    localparam int EC_SA[7] = '{0, 0, 0, 0, 1, 1, 1};
    localparam int DO_WR[3] = '{0, 5, 4};
    localparam int DB_WR[3] = '{1, 0, 0};
    localparam int DW_WR[3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic clear;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mod_updown_counter_if #(.DATA_BITS(8)) bus ();

    mod_updown_counter #(.DATA_BITS(8), .MAX_VALUE(5)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 1'b0;
        bus.load = 1'b0; bus.data = '0;
        bus.limit_load = 1'b0; bus.limit_data = '0;
        bus.count = 1'b0; bus.down = 1'b0;
    endtask

    initial begin
        idle();
        clear = 1'b1;
        #1;
        chk("init_out", 32'(bus.out), 0);
        chk("init_limit", 32'(bus.limit), 5);
        chk("init_wrap", 32'(bus.wrap), 0);

        step();
        chk("clr_out", 32'(bus.out), 0);
        chk("clr_limit", 32'(bus.limit), 5);
        chk("clr_carry", 32'(bus.carry), 0);
        bus.down = 1'b1; #1;
        chk("clr_borrow", 32'(bus.borrow), 1);

        // Count up through the limit
        idle(); bus.count = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("up_out", 32'(bus.out), SAT ? EO_SA[i] : EO_WR[i]);
            chk("up_wrap", 32'(bus.wrap), SAT ? 0 : EW_WR[i]);
            chk("up_carry", 32'(bus.carry), SAT ? EC_SA[i] : EC_WR[i]);
        end

        // Count down through zero from out=1
        idle(); bus.load = 1'b1; bus.data = 8'd1;
        step();
        chk("ld1_out", 32'(bus.out), 1);
        idle(); bus.count = 1'b1; bus.down = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dn_out", 32'(bus.out), SAT ? 0 : DO_WR[i]);
            chk("dn_borrow", 32'(bus.borrow), SAT ? 1 : DB_WR[i]);
            chk("dn_wrap", 32'(bus.wrap), SAT ? 0 : DW_WR[i]);
        end

        // Load clamp against current and same-cycle limit
        idle(); bus.load = 1'b1; bus.data = 8'd9;
        step();
        chk("clamp_out", 32'(bus.out), 5);
        chk("clamp_wrap", 32'(bus.wrap), 0);
        bus.limit_load = 1'b1; bus.limit_data = 8'd3;
        step();
        chk("clamp2_limit", 32'(bus.limit), 3);
        chk("clamp2_out", 32'(bus.out), 3);

        // Limit shrink below the count, count ignored
        bus.limit_data = 8'd10; bus.data = 8'd7;
        step();
        chk("ld7_out", 32'(bus.out), 7);
        chk("ld7_limit", 32'(bus.limit), 10);
        idle(); bus.limit_load = 1'b1; bus.limit_data = 8'd4; bus.count = 1'b1;
        step();
        chk("shrink_out", 32'(bus.out), 0);
        chk("shrink_limit", 32'(bus.limit), 4);
        chk("shrink_wrap", 32'(bus.wrap), 0);
        idle(); bus.load = 1'b1; bus.data = 8'd2;
        step();
        idle(); bus.limit_load = 1'b1; bus.limit_data = 8'd10;
        step();
        chk("grow_out", 32'(bus.out), 2);
        chk("grow_limit", 32'(bus.limit), 10);

        // Hold with count=0
        idle();
        step();
        chk("hold_out", 32'(bus.out), 2);
        chk("hold_limit", 32'(bus.limit), 10);

        // Wrap pulse is cleared by a following limit_load edge
        idle(); bus.load = 1'b1; bus.data = 8'd10;
        step();
        idle(); bus.count = 1'b1;
        step();
        chk("wr_out", 32'(bus.out), SAT ? 10 : 0);
        chk("wr_wrap", 32'(bus.wrap), SAT ? 0 : 1);
        bus.limit_load = 1'b1; bus.limit_data = 8'd10;
        step();
        chk("wr_ll_out", 32'(bus.out), SAT ? 10 : 0);
        chk("wr_ll_wrap", 32'(bus.wrap), 0);

        // Clear beats load and count
        idle(); clear = 1'b1; bus.load = 1'b1; bus.data = 8'd3; bus.count = 1'b1;
        step();
        chk("prio_out", 32'(bus.out), 0);
        chk("prio_limit", 32'(bus.limit), 5);
        chk("prio_wrap", 32'(bus.wrap), 0);

        // limit=0: every count is a wrap event
        idle(); bus.limit_load = 1'b1; bus.limit_data = 8'd0;
        step();
        chk("l0_limit", 32'(bus.limit), 0);
        idle(); bus.count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("l0_out", 32'(bus.out), 0);
            chk("l0_wrap", 32'(bus.wrap), SAT ? 0 : 1);
            chk("l0_carry", 32'(bus.carry), 1);
        end
        bus.down = 1'b1;
        step();
        chk("l0d_borrow", 32'(bus.borrow), 1);
        chk("l0d_wrap", 32'(bus.wrap), SAT ? 0 : 1);
        bus.count = 1'b0;
        step();
        chk("l0h_wrap", 32'(bus.wrap), 0);
        chk("l0h_out", 32'(bus.out), 0);

        // End point at limit=5, out=5 counting up
        idle(); bus.limit_load = 1'b1; bus.limit_data = 8'd5; bus.load = 1'b1; bus.data = 8'd5;
        step();
        idle(); bus.count = 1'b1;
        step();
        chk("sat_up_out", 32'(bus.out), SAT ? 5 : 0);
        chk("sat_up_wrap", 32'(bus.wrap), SAT ? 0 : 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
